// File: rtl/instr_issue_queue.sv
// ---------------------------------------------------------------------------
// instr_issue_queue
//
// Small circular FIFO that buffers decoded instruction words in front of the
// ALU. The loader pushes words. The ALU side takes the oldest word through a
// valid/ready handshake. The queue absorbs loader bursts while the consumer
// stalls, and it reports its occupancy and a sticky overflow status.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   push       loader presents iw_in this cycle
//   iw_in      instruction word to enqueue
//   flush      synchronous discard of every queued entry; has priority
//   iw_out     oldest queued word (all-zero when the queue is empty)
//   valid_out  iw_out holds a real entry
//   ready_in   consumer accepts iw_out this cycle
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: a push was dropped because the queue was full
//
// Optional feature (macro INSTR_QUEUE_BYPASS_EN):
//   When the macro is defined and the queue is empty, a pushed word is
//   forwarded combinationally to iw_out in the same cycle. If ready_in is
//   also high, the word is consumed without being stored. When the macro is
//   undefined, push-to-valid latency is one cycle.
// ---------------------------------------------------------------------------

package definitions_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'h0,
    SUB   = 4'h1,
    AND   = 4'h2,
    OR    = 4'h3,
    XOR   = 4'h4,
    SLL   = 4'h5,
    SRL   = 4'h6,
    PASSA = 4'h7
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } instruction_t;

endpackage

module instr_issue_queue
  import definitions_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  instruction_t     iw_in,
  input  logic             flush,
  output instruction_t     iw_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  instruction_t     mem [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic isEmpty;
  logic isFull;
  logic bypassValid;
  logic bypassTake;
  logic storePop;
  logic accPush;
  logic doWrite;
  logic dropPush;

  // Status flags come from registered state only, so full/empty/count have
  // no combinational path from push or ready_in.
  always_comb begin
    isEmpty = (count_q == '0);
    isFull  = (count_q == CNT_W'(DEPTH));
  end

  // Bypass is offered only into an empty queue and never while flushing.
  always_comb begin
`ifdef INSTR_QUEUE_BYPASS_EN
    bypassValid = isEmpty && push && !flush;
`else
    bypassValid = 1'b0;
`endif
  end

  // Handshake decode. A bypassed word that the consumer takes right away is
  // never written, so the queue stays empty. A push into a full queue is
  // still accepted when an entry leaves in the same cycle.
  always_comb begin
    storePop   = !isEmpty && ready_in;
    bypassTake = bypassValid && ready_in;
    accPush    = push && (!isFull || storePop);
    doWrite    = accPush && !bypassTake && !flush;
    dropPush   = push && isFull && !storePop;
  end

  // Next-state logic. Flush wins over any push or pop in the same cycle.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (doWrite) begin
        wp_d = wp_q + PTR_W'(1);
      end
      if (storePop) begin
        rp_d = rp_q + PTR_W'(1);
      end
      unique case ({doWrite, storePop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      overflow_d = overflow_q || dropPush;
    end
  end

  // Control state. Reset discards all entries immediately, without waiting
  // for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array. It has no reset; entries are only ever read while the
  // queue is non-empty. Popped entries are left in place.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wp_q] <= iw_in;
    end
  end

  // First-word-fall-through output. An empty queue shows all-zero unless a
  // word is being bypassed.
  always_comb begin
    if (!isEmpty) begin
      iw_out = mem[rp_q];
    end else if (bypassValid) begin
      iw_out = iw_in;
    end else begin
      iw_out = '0;
    end
    valid_out = !isEmpty || bypassValid;
    count     = count_q;
    full      = isFull;
    empty     = isEmpty;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_queue
//
// Testbench for instr_issue_queue with DEPTH = 4. Each table entry drives one
// clock cycle of inputs and gives the occupancy, status flags and head word
// expected afterwards. Hand-written sequences cover reset, a reset in the
// middle of a burst, and same-cycle push-to-valid behaviour.
// ---------------------------------------------------------------------------

module tb_instr_issue_queue;
  import definitions_pkg::*;

  logic         clk;
  logic         rst;
  logic         push;
  instruction_t iw_in;
  logic         flush;
  instruction_t iw_out;
  logic         valid_out;
  logic         ready_in;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         push;
    logic         flush;
    logic         ready;
    instruction_t iw;
    logic [2:0]   expCount;
    logic         expOvf;
    instruction_t expIw;
  } vec_t;

  vec_t vecs[$];

  instr_issue_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .iw_in     (iw_in),
    .flush     (flush),
    .iw_out    (iw_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stops a hung run with a failure instead of spinning forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic instruction_t mk(input opcode_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    instruction_t w;
    w.opcode = op;
    w.a      = a;
    w.b      = b;
    return w;
  endfunction

  // Queues one table entry. The flags are derived from the expected count.
  task automatic addVec(input logic p, input logic f, input logic r,
                        input instruction_t iw, input logic [2:0] cnt,
                        input logic ovf, input instruction_t expIw);
    vec_t v;
    v.push     = p;
    v.flush    = f;
    v.ready    = r;
    v.iw       = iw;
    v.expCount = cnt;
    v.expOvf   = ovf;
    v.expIw    = expIw;
    vecs.push_back(v);
  endtask

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks the whole visible state of the queue.
  task automatic checkState(input string name, input logic [2:0] cnt,
                            input logic ovf, input instruction_t expIw);
    checkOutput({name, " status"}, {count, valid_out, full, empty, overflow},
                {cnt, cnt != 3'd0, cnt == 3'd4, cnt == 3'd0, ovf});
    checkOutput({name, " iw_out"}, iw_out, expIw);
  endtask

  // Drives one cycle of inputs, then idles the inputs so that the check
  // sees registered state only.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    push     = v.push;
    flush    = v.flush;
    ready_in = v.ready;
    iw_in    = v.iw;
    @(posedge clk);
    #1;
    push     = 1'b0;
    flush    = 1'b0;
    ready_in = 1'b0;
    iw_in    = '0;
    #1;
  endtask

  initial begin
    instruction_t zw;
    instruction_t wA;
    instruction_t wS;
    instruction_t wO;
    instruction_t w[6];
    instruction_t p[11];
    instruction_t q[8];

    zw = '0;
    wA = mk(ADD, 32'd5, 32'd3);
    wS = mk(SUB, 32'd9, 32'd4);
    wO = mk(OR, 32'hF0, 32'h0F);
    for (int i = 0; i < 6; i++) begin
      w[i] = mk(opcode_e'(4'(i)), 32'h1000 + i, 32'h2000 + i);
    end
    // Unimplemented opcode value; it must pass through untouched.
    w[3] = mk(opcode_e'(4'hE), 32'hDEAD_0003, 32'hBEEF_0003);
    for (int i = 0; i < 11; i++) begin
      p[i] = mk(opcode_e'(4'(i % 8)), 32'h3000 + i, 32'h4000 + i);
    end
    for (int i = 0; i < 8; i++) begin
      q[i] = mk(XOR, 32'h5000 + i, 32'h6000 + i);
    end

    // Two pushes, then two pops, then a pop attempt on an empty queue.
    addVec(1, 0, 0, wA, 3'd1, 0, wA);
    addVec(1, 0, 0, wS, 3'd2, 0, wA);
    addVec(0, 0, 1, zw, 3'd1, 0, wS);
    addVec(0, 0, 1, zw, 3'd0, 0, zw);
    addVec(0, 0, 1, zw, 3'd0, 0, zw);
    // Five pushes into four slots: the fifth is dropped, overflow sticks.
    for (int k = 1; k <= 4; k++) addVec(1, 0, 0, w[k], 3'(k), 0, w[1]);
    addVec(1, 0, 0, w[5], 3'd4, 1, w[1]);
    addVec(0, 0, 1, zw, 3'd3, 1, w[2]);
    addVec(0, 0, 1, zw, 3'd2, 1, w[3]);
    addVec(0, 0, 1, zw, 3'd1, 1, w[4]);
    addVec(0, 0, 1, zw, 3'd0, 1, zw);
    addVec(0, 1, 0, zw, 3'd0, 0, zw);
    // Full queue with push and pop together across pointer wrap.
    for (int k = 1; k <= 4; k++) addVec(1, 0, 0, p[k], 3'(k), 0, p[1]);
    for (int k = 1; k <= 6; k++) addVec(1, 0, 1, p[4+k], 3'd4, 0, p[k+1]);
    addVec(0, 0, 1, zw, 3'd3, 0, p[8]);
    addVec(0, 0, 1, zw, 3'd2, 0, p[9]);
    addVec(0, 0, 1, zw, 3'd1, 0, p[10]);
    addVec(0, 0, 1, zw, 3'd0, 0, zw);
    // Flush with a coincident push on a three-entry queue with overflow set.
    for (int k = 1; k <= 4; k++) addVec(1, 0, 0, q[k], 3'(k), 0, q[1]);
    addVec(1, 0, 0, q[5], 3'd4, 1, q[1]);
    addVec(0, 0, 1, zw, 3'd3, 1, q[2]);
    addVec(1, 1, 0, q[6], 3'd0, 0, zw);
    addVec(1, 0, 0, q[7], 3'd1, 0, q[7]);
    addVec(0, 0, 1, zw, 3'd0, 0, zw);

    // Reset held for three cycles.
    rst      = 1'b1;
    push     = 1'b0;
    flush    = 1'b0;
    ready_in = 1'b0;
    iw_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkState("reset", 3'd0, 1'b0, zw);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expOvf,
                 vecs[i].expIw);
    end

    // Reset between clock edges in the middle of a burst.
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    checkState("burst", 3'd2, 1'b0, wA);
    #1;
    rst = 1'b1;
    #1;
    checkState("async_reset", 3'd0, 1'b0, zw);
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle visibility of a word pushed into an empty queue.
    @(negedge clk);
    push     = 1'b1;
    ready_in = 1'b1;
    iw_in    = wO;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    checkOutput("push_cycle valid", valid_out, 1'b1);
    checkOutput("push_cycle iw_out", iw_out, wO);
`else
    checkOutput("push_cycle valid", valid_out, 1'b0);
    checkOutput("push_cycle iw_out", iw_out, zw);
`endif
    @(posedge clk);
    #1;
    push     = 1'b0;
    ready_in = 1'b0;
    iw_in    = '0;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    checkState("after_push", 3'd0, 1'b0, zw);
`else
    checkState("after_push", 3'd1, 1'b0, wO);
`endif
    applyStimulus(vecs[$]);
    checkState("drained", 3'd0, 1'b0, zw);

    // Flush with push into an empty queue shows nothing and stores nothing.
    @(negedge clk);
    push  = 1'b1;
    flush = 1'b1;
    iw_in = wO;
    #1;
    checkOutput("flush_push valid", valid_out, 1'b0);
    @(posedge clk);
    #1;
    push  = 1'b0;
    flush = 1'b0;
    iw_in = '0;
    #1;
    checkState("flush_push", 3'd0, 1'b0, zw);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
